// File: rtl/regfile_write_port_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_port_pkg
// Shared constants and helpers for the register-file write side.
//   AW         : register address width
//   DW         : data width (array word width)
//   NREG       : number of architectural registers (2**AW)
//   onehot_dec : rd -> one-hot register enable; register 0 never decodes,
//                so the same helper also serves the array-side decoder
// ---------------------------------------------------------------------------
package regfile_write_port_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  // Register 0 is hard-wired, so it maps to an all-zero enable.
  function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] rd);
    onehot_dec = '0;
    if (rd != '0) onehot_dec[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_write_port_if.sv
// ---------------------------------------------------------------------------
// regfile_write_port_if
// Bundle between the writeback producer / array and the write port.
//   in_valid/in_ready/in_rd/in_data : writeback request handshake
//   hold                            : stall draining into the array
//   D/En                            : registered data bus and one-hot enables
//   busy                            : per-register pending-write mask
//   count                           : FIFO occupancy (output stage excluded)
// master = producer/array side, slave = write port.
// ---------------------------------------------------------------------------
interface regfile_write_port_if
  import regfile_write_port_pkg::*;
#(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rd;
  logic [DW-1:0]   in_data;
  logic            hold;
  logic [DW-1:0]   D;
  logic [NREG-1:0] En;
  logic [NREG-1:0] busy;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_rd, in_data, hold,
    input  in_ready, D, En, busy, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, hold,
    output in_ready, D, En, busy, count
  );

endinterface

// File: rtl/regfile_write_port_fifo.sv
// ---------------------------------------------------------------------------
// wp_fifo
// DEPTH-entry FIFO of (rd, data) write requests.
//   Clk, Clrn        : clock, synchronous active-low reset
//   i_push/i_rd/i_data : enqueue (caller guarantees not full)
//   i_pop            : dequeue head (caller guarantees not empty)
//   o_head_rd/o_head_data : current head entry
//   o_rds/o_valid    : every slot's rd plus an occupancy mask, so the
//                      owner can build a pending-write mask
//   o_count/o_full/o_empty : occupancy
// ---------------------------------------------------------------------------
module wp_fifo
  import regfile_write_port_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           Clk,
  input  logic                           Clrn,
  input  logic                           i_push,
  input  logic [AW-1:0]                  i_rd,
  input  logic [DW-1:0]                  i_data,
  input  logic                           i_pop,
  output logic [AW-1:0]                  o_head_rd,
  output logic [DW-1:0]                  o_head_data,
  output logic [DEPTH-1:0][AW-1:0]       o_rds,
  output logic [DEPTH-1:0]               o_valid,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_rd_mem   [DEPTH];
  logic [DW-1:0] r_data_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Payload storage carries no reset; stale slots are masked by o_valid.
  always_ff @(posedge Clk) begin
    if (i_push) begin
      r_rd_mem[r_wr_ptr]   <= i_rd;
      r_data_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // A slot is occupied when its distance from the read pointer is below count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] w_off;
      assign w_off       = PW'(gi) - r_rd_ptr;
      assign o_valid[gi] = (CW'(w_off) < r_count);
      assign o_rds[gi]   = r_rd_mem[gi];
    end
  endgenerate

  assign o_head_rd   = r_rd_mem[r_rd_ptr];
  assign o_head_data = r_data_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/regfile_write_port.sv
// ---------------------------------------------------------------------------
// regfile_write_port
// Write-side front end of the 32x32 register array. Buffers writeback
// requests, drains one per cycle into registered D/En, and publishes a
// pending-write mask (busy) for decode-stage hazard checks.
//   Clk  : clock
//   Clrn : synchronous active-low reset
//   bus  : regfile_write_port_if.slave (handshake, hold, D, En, busy, count)
// DEPTH must match the DEPTH of the connected interface instance.
// ---------------------------------------------------------------------------
module regfile_write_port
  import regfile_write_port_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 Clk,
  input  logic                 Clrn,
  regfile_write_port_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                     w_accept;
  logic                     w_enq;
  logic                     w_pop;
  logic [AW-1:0]            w_head_rd;
  logic [DW-1:0]            w_head_data;
  logic [DEPTH-1:0][AW-1:0] w_rds;
  logic [DEPTH-1:0]         w_valid;
  logic [CW-1:0]            w_count;
  logic                     w_full;
  logic                     w_empty;
  logic [NREG-1:0]          w_busy_next;

  logic [DW-1:0]            r_D;
  logic [NREG-1:0]          r_En;
  logic [NREG-1:0]          r_busy;

  // in_ready depends only on registered occupancy and reset, never on hold.
  assign bus.in_ready = !w_full && Clrn;
  assign w_accept     = bus.in_valid && bus.in_ready;
  // Writes to register 0 complete the handshake but are discarded here.
  assign w_enq        = w_accept && (bus.in_rd != '0);
  assign w_pop        = Clrn && !bus.hold && !w_empty;

  wp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk         (Clk),
    .Clrn        (Clrn),
    .i_push      (w_enq),
    .i_rd        (bus.in_rd),
    .i_data      (bus.in_data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_rds       (w_rds),
    .o_valid     (w_valid),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Post-edge pending set: every entry now queued either stays queued or
  // moves to the output stage, and the old output stage retires, so the
  // next mask is simply current entries plus any incoming request.
  always_comb begin
    w_busy_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) w_busy_next = w_busy_next | onehot_dec(w_rds[i]);
    end
    if (w_enq) w_busy_next = w_busy_next | onehot_dec(bus.in_rd);
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      r_D    <= '0;
      r_En   <= '0;
      r_busy <= '0;
    end else begin
      if (w_pop) begin
        r_D  <= w_head_data;
        r_En <= onehot_dec(w_head_rd);
      end else begin
        r_En <= '0;
      end
      r_busy <= w_busy_next;
    end
  end

  assign bus.D     = r_D;
  assign bus.En    = r_En;
  assign bus.busy  = r_busy;
  assign bus.count = w_count;

  a_en_onehot : assert property (@(posedge Clk) disable iff (!Clrn)
    $onehot0(r_En) && !r_En[0] && !r_busy[0]);

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
Write-side front end for the 32x32 register array. Accepts writeback requests (rd, data) over a valid/ready handshake and buffers them in a small FIFO. Drains one request per cycle into registered D/En outputs that drive the array's shared data bus and one-hot per-register enables. Publishes a per-register pending-write mask for hazard detection in the decode stage.

Parameters:
DEPTH, 2, FIFO entries (power of two, >=2)
DW, 32, data width; equals array word width
AW, 5, register address width; array has 2**AW registers

Ports:
Clk  input  1  clock; all state updates on rising edge
Clrn  input  1  reset, synchronous, active-low
in_valid  input  1  writeback request present
in_ready  output  1  FIFO can accept; = (count < DEPTH) && Clrn
in_rd  input  AW  destination register
in_data  input  DW  write data
hold  input  1  when 1: no pop; En forced to 0 next cycle
D  output  DW  registered write data to array
En  output  2**AW  registered one-hot write enable to array; bit 0 never set
busy  output  2**AW  bit r = 1 if any FIFO entry or the output stage targets r
count  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the output stage

Behaviour:
- Reset: Clk edge with Clrn=0 sets FIFO empty, count=0, D=0, En=0, busy=0. in_ready=0 while Clrn=0. Reset mid-operation discards all queued and in-flight writes; no En pulse after that edge.
- Accept: push on an edge where in_valid && in_ready.
- Zero-register drop: in_rd==0 is accepted (handshake completes) but not enqueued. count and busy are unchanged.
- Pop: on each edge with Clrn=1, hold=0 and count>0, the head is popped into the output stage: D<=head.data, En<=1<<head.rd.
- Idle output: on edges with no pop (empty or hold=1), En<=0 and D holds its value.
- Latency: a request accepted at edge t into an empty FIFO appears on D/En after edge t+1. The array captures it at edge t+2.
- Throughput: one write per cycle sustained.
- Same edge push and pop: allowed; count unchanged. in_ready uses registered count only, so there is no combinational path from hold to in_ready. Full with pop pending still reports in_ready=0.
- Ordering: strict FIFO order. Two queued writes to the same rd land in arrival order; the last one wins in the array.
- busy is registered and recomputed each edge as OR over valid FIFO entries plus the output stage (if En!=0) of the decoded rd. busy[0]=0 always. busy[r] stays 1 until the edge after the array write, i.e. while En[r]=1.
- Pointers: wrap modulo DEPTH. count saturates by construction (push is blocked when full). Popping when empty is impossible.
- En is one-hot or zero every cycle (checked by assertion).

Decomposition:
- Shared package: AW, DW, NREG=2**AW, and the function onehot_dec(rd) returning NREG bits, also reused by the array-side decoder.
- One sub-module, wp_fifo (DEPTH x (AW+DW), count, push/pop, full/empty).
- Decode, output stage and busy generation stay in the top.

Test Plan:
- Reset: hold Clrn=0 for 2 cycles with in_valid=1 -> in_ready=0, En=0, D=0, busy=0, count=0.
- Single write: rd=5, data=32'hDEADBEEF at edge t -> edge t+1 gives En=32'h20, D=DEADBEEF, busy[5]=1. Edge t+2 gives En=0, busy=0.
- rd=0 request with data=32'h1234 -> handshake completes; count stays 0, En stays 0, busy stays 0.
- Backpressure: hold=1, push rd=1,2,3 -> two accepts, then in_ready=0, count=2, busy=32'h6. Release hold -> En=32'h2 then 32'h4. The third push is accepted once count<2.
- Same-rd ordering: push (7,0xA) then (7,0xB) back-to-back -> En=32'h80 two consecutive cycles with D=0xA then 0xB. busy[7] stays 1 throughout.
- Mid-operation reset: queue rd=9,10 and assert Clrn=0 for one edge -> no En pulse afterward, count=0, busy=0. Traffic resumes normally.
